lcd_writer: RTL and testbench
=============================

LCD_WRITER -- requirements
Module: lcd_writer

Interface
REQ-001 SHALL have parameter EN_CYCLES, default 25, lcd_en high-pulse width in clk cycles.
REQ-002 SHALL have parameter CMD_WAIT, default 2500, post-write wait in cycles for ordinary commands and characters.
REQ-003 SHALL have parameter CLR_WAIT, default 100000, post-write wait in cycles after clear (0x01).
REQ-004 SHALL have parameter PWR_WAIT, default 1000000, power-up delay in cycles before the first write.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port opcode, input, 4, live instruction opcode to display.
REQ-008 SHALL have port imm4, input, 4, live immediate to display.
REQ-009 SHALL have port refresh, input, 1, single-cycle pulse requesting a redraw.
REQ-010 SHALL have port rom_addr, output, 5, character index to the character ROM (0-15 line 1, 16-31 line 2).
REQ-011 SHALL have port rom_opcode, output, 4, snapshot opcode driven to the ROM.
REQ-012 SHALL have port rom_imm4, output, 4, snapshot imm4 driven to the ROM.
REQ-013 SHALL have port lcd_val, input, 8, ASCII byte returned combinationally by the ROM.
REQ-014 SHALL have ports lcd_data (output, 8), lcd_rs (output, 1), lcd_rw (output, 1) and lcd_en (output, 1), forming the HD44780 8-bit bus.
REQ-015 SHALL have port busy, output, 1, high whenever not in IDLE.

Function
REQ-016 Top FSM states SHALL be PWR, INIT, IDLE, HOME, CHAR, LINE2; transitions are PWR->INIT->IDLE->HOME->CHAR(0-15)->LINE2->CHAR(16-31)->IDLE.
REQ-017 PWR SHALL count PWR_WAIT cycles, then go to INIT.
REQ-018 INIT SHALL write commands 0x38, 0x0C, 0x06, 0x01 in order, rs=0.
REQ-019 Each byte write SHALL follow this sequence: SETUP 1 cycle (data/rs stable, en=0), then PULSE EN_CYCLES cycles (en=1), then WAIT (en=0) for CMD_WAIT cycles (CLR_WAIT cycles after 0x01); the next byte starts only after WAIT ends.
REQ-020 lcd_data and lcd_rs SHALL stay constant from SETUP through the end of PULSE; lcd_rw SHALL be 0 at all times.
REQ-021 Leaving IDLE SHALL occur on refresh=1, or when {opcode,imm4} != {rom_opcode,rom_imm4}; on that cycle the snapshot is loaded from the live inputs.
REQ-022 IDLE SHALL ignore input changes for one cycle after the snapshot load; mid-frame changes are not sampled and cause a new frame after the return to IDLE.
REQ-023 HOME SHALL write 0x80 (rs=0); LINE2 SHALL write 0xC0 (rs=0) between addr 15 and addr 16.
REQ-024 CHAR SHALL drive rom_addr at least 1 cycle before SETUP, latch lcd_val into lcd_data at SETUP, write with rs=1, then increment rom_addr.
REQ-025 After addr 31 completes WAIT, rom_addr SHALL wrap to 0 and the FSM SHALL return to IDLE; busy falls that cycle.
REQ-026 A refresh pulse arriving while busy SHALL be latched as pending and serviced on return to IDLE; multiple pulses collapse to one.
REQ-027 Frame length SHALL be exactly 34 byte writes: 2 commands plus 32 characters.

Reset
REQ-028 While rst_n=0 at a clk edge, the block SHALL set: state PWR, all counters 0, rom_addr 0, rom_opcode 0, rom_imm4 0, lcd_data 0x00, lcd_rs 0, lcd_rw 0, lcd_en 0, busy 1, pending refresh 0.
REQ-029 Reset mid-write, including during PULSE, SHALL drop lcd_en on the same edge and restart from PWR.

Structure
REQ-030 Command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) and state encodings SHALL reside in a shared package/include, lcd_defs.
REQ-031 Byte timing (SETUP/PULSE/WAIT) SHALL be a sub-module lcd_byte_tx with start/done handshake and inputs byte, rs, long_wait; done is a 1-cycle pulse at the end of WAIT, and start is ignored while it is active.

Verification (EN_CYCLES=2, CMD_WAIT=4, CLR_WAIT=8, PWR_WAIT=10)
REQ-032 Reset release -> lcd_en stays 0 for 10 cycles, then 4 pulses carrying 0x38, 0x0C, 0x06, 0x01 with rs=0; gap after 0x01 is 8 cycles; busy is 0 afterwards.
REQ-033 After init, opcode=0x1, imm4=0x5 -> snapshot 0x1/0x5; writes 0x80, then 16 rs=1 bytes equal to the ROM at addr 0-15, then 0xC0, then addr 16-31; 34 en pulses in total, each 2 cycles high.
REQ-034 refresh pulse with unchanged inputs -> exactly one new 34-write frame; a second refresh mid-frame -> exactly one further frame.
REQ-035 opcode changes 0x2->0x3 mid-frame -> current frame completes with rom_opcode=0x2, then a new frame runs with rom_opcode=0x3.
REQ-036 rst_n=0 asserted during a PULSE cycle -> lcd_en=0 on the next edge, all outputs at reset values, PWR wait restarts.
REQ-037 Check every pulse -> lcd_data/lcd_rs constant from SETUP to PULSE end, lcd_rw=0 throughout, rom_addr wraps 31->0 at the end of each frame.

Source files
------------

// File: rtl/lcd_defs.sv
// Shared definitions for the HD44780 writer: FSM encodings and the fixed
// command bytes used during init and line addressing.
package lcd_defs;

    typedef enum logic [2:0] {
        ST_PWR,
        ST_INIT,
        ST_IDLE,
        ST_HOME,
        ST_CHAR,
        ST_LINE2
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_WAIT
    } tx_phase_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [4:0] ADDR_LINE1_END = 5'd15;
    localparam logic [4:0] ADDR_LAST      = 5'd31;

    // Init sequence order: 8-bit/2-line, display on, auto-increment, clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One HD44780 bus write: SETUP (1 cycle), PULSE (en high), then a settle WAIT.
// done pulses on the last WAIT cycle; start is ignored until then.
module lcd_byte_tx
    import lcd_defs::*;
#(
    parameter int EN_CYCLES = 25,
    parameter int CMD_WAIT  = 2500,
    parameter int CLR_WAIT  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       rs,
    input  logic       long_wait,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       done
);

    localparam logic [31:0] PULSE_LAST = 32'(EN_CYCLES - 1);
    localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT - 1);
    localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT - 1);

    tx_phase_t   phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        long_q, long_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= TX_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        long_d  = long_q;
        done    = 1'b0;
        case (phase_q)
            TX_IDLE: begin
                if (start) begin
                    data_d  = tx_byte;
                    rs_d    = rs;
                    long_d  = long_wait;
                    cnt_d   = '0;
                    phase_d = TX_SETUP;
                end
            end
            TX_SETUP: begin
                cnt_d   = '0;
                phase_d = TX_PULSE;
            end
            TX_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    phase_d = TX_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                if (cnt_q == (long_q ? CLR_LAST : CMD_LAST)) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    phase_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
        endcase
    end

    // data/rs are registered at start, so they are stable across SETUP and PULSE.
    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_en   = (phase_q == TX_PULSE);

endmodule

// File: rtl/lcd_writer.sv
// Renders a 2x16 opcode/immediate view on an HD44780: power-up wait, init
// commands, then a 34-write frame whenever the inputs change or refresh is asked.
module lcd_writer
    import lcd_defs::*;
#(
    parameter int EN_CYCLES = 25,
    parameter int CMD_WAIT  = 2500,
    parameter int CLR_WAIT  = 100000,
    parameter int PWR_WAIT  = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic [3:0] imm4,
    input  logic       refresh,
    output logic [4:0] rom_addr,
    output logic [3:0] rom_opcode,
    output logic [3:0] rom_imm4,
    input  logic [7:0] lcd_val,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       busy
);

    localparam logic [31:0] PWR_LAST = 32'(PWR_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic        sent_q, sent_d;
    logic [4:0]  addr_q, addr_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  imm_q, imm_d;
    logic        pend_q, pend_d;
    logic        hold_q, hold_d;

    logic        tx_start, tx_rs, tx_long, tx_done;
    logic [7:0]  tx_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_PWR;
            cnt_q      <= '0;
            init_idx_q <= 2'd0;
            sent_q     <= 1'b0;
            addr_q     <= 5'd0;
            op_q       <= 4'h0;
            imm_q      <= 4'h0;
            pend_q     <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            sent_q     <= sent_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        sent_d     = sent_q;
        addr_d     = addr_q;
        op_d       = op_q;
        imm_d      = imm_q;
        pend_d     = pend_q;
        hold_d     = hold_q;
        tx_start   = 1'b0;
        tx_byte    = 8'h00;
        tx_rs      = 1'b0;
        case (state_q)
            ST_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_INIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_INIT: begin
                tx_byte = init_cmd(init_idx_q);
                if (tx_done) begin
                    init_idx_d = init_idx_q + 2'd1;
                    if (init_idx_q == 2'd3) state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Input compare is masked for one IDLE cycle after a snapshot load.
                hold_d = 1'b0;
                if (refresh || pend_q ||
                    (!hold_q && ({opcode, imm4} != {op_q, imm_q}))) begin
                    op_d    = opcode;
                    imm_d   = imm4;
                    pend_d  = 1'b0;
                    hold_d  = 1'b1;
                    state_d = ST_HOME;
                end
            end
            ST_HOME: begin
                tx_byte = CMD_LINE1;
                if (tx_done) state_d = ST_CHAR;
            end
            ST_CHAR: begin
                tx_byte = lcd_val;
                tx_rs   = 1'b1;
                if (tx_done) begin
                    addr_d = addr_q + 5'd1;
                    if (addr_q == ADDR_LINE1_END) state_d = ST_LINE2;
                    else if (addr_q == ADDR_LAST)  state_d = ST_IDLE;
                end
            end
            ST_LINE2: begin
                tx_byte = CMD_LINE2;
                if (tx_done) state_d = ST_CHAR;
            end
            default: state_d = ST_PWR;
        endcase

        // One start per byte state; done re-arms it for the following byte.
        if (state_q inside {ST_INIT, ST_HOME, ST_CHAR, ST_LINE2}) begin
            tx_start = !sent_q;
            if (tx_done)      sent_d = 1'b0;
            else if (!sent_q) sent_d = 1'b1;
        end

        if (refresh && state_q != ST_IDLE) pend_d = 1'b1;
    end

    assign tx_long = (tx_byte == CMD_CLEAR) && !tx_rs;

    lcd_byte_tx #(
        .EN_CYCLES(EN_CYCLES),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tx_start),
        .tx_byte  (tx_byte),
        .rs       (tx_rs),
        .long_wait(tx_long),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en),
        .done     (tx_done)
    );

    assign rom_addr   = addr_q;
    assign rom_opcode = op_q;
    assign rom_imm4   = imm_q;
    assign lcd_rw     = 1'b0;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_writer.sv
// Bench for lcd_writer: a bus monitor compares every write against an
// expected-write queue built from frame-level rules, plus bus timing checks.
module tb_lcd_writer;

    localparam int EN   = 2;
    localparam int CMDW = 4;
    localparam int CLRW = 8;
    localparam int PWRW = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [3:0] imm4 = 4'h0;
    logic       refresh = 1'b0;
    logic [4:0] rom_addr;
    logic [3:0] rom_opcode, rom_imm4;
    logic [7:0] lcd_val, lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, busy;

    always #5 clk = ~clk;

    lcd_writer #(
        .EN_CYCLES(EN), .CMD_WAIT(CMDW), .CLR_WAIT(CLRW), .PWR_WAIT(PWRW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imm4(imm4), .refresh(refresh),
        .rom_addr(rom_addr), .rom_opcode(rom_opcode), .rom_imm4(rom_imm4),
        .lcd_val(lcd_val), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .busy(busy)
    );

    // Character ROM stand-in: any fixed function of (addr, opcode, imm4).
    function automatic logic [7:0] rom_fn(input logic [4:0] a, input logic [3:0] op,
                                          input logic [3:0] im);
        return (8'h30 + {3'b000, a} + {op, 4'h0}) ^ {4'h0, im};
    endfunction
    assign lcd_val = rom_fn(rom_addr, rom_opcode, rom_imm4);

    typedef struct {
        logic [7:0] data;
        logic       rs;
        logic       is_char;
        logic [4:0] addr;
        logic [3:0] op;
        logic [3:0] imm;
    } wr_t;

    wr_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         nwrites = 0;
    logic [7:0] char0_data = 8'h00;
    logic [3:0] snap_op = 4'h0;
    logic [3:0] snap_imm = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_cmd(input logic [7:0] b);
        wr_t e;
        e.data = b; e.rs = 1'b0; e.is_char = 1'b0; e.addr = 5'd0; e.op = 4'h0; e.imm = 4'h0;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h06); push_cmd(8'h01);
    endtask

    task automatic push_frame(input logic [3:0] op, input logic [3:0] im);
        wr_t e;
        push_cmd(8'h80);
        for (int a = 0; a < 32; a++) begin
            if (a == 16) push_cmd(8'hC0);
            e.addr = 5'(a); e.op = op; e.imm = im; e.rs = 1'b1; e.is_char = 1'b1;
            e.data = rom_fn(5'(a), op, im);
            exp_q.push_back(e);
        end
        snap_op  = op;
        snap_imm = im;
    endtask

    // Bus monitor: write stream, pulse width, setup/pulse stability, rw, frame end.
    initial begin : monitor
        logic       en_prev = 1'b0, busy_prev = 1'b1, init_seen = 1'b0;
        logic [7:0] prev_data = 8'h00, pulse_data = 8'h00;
        logic       prev_rs = 1'b0, pulse_rs = 1'b0;
        int         hi_cnt = 0, wcount = 0;
        wr_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_prev = 1'b0; busy_prev = 1'b1; init_seen = 1'b0;
                hi_cnt = 0; wcount = 0;
            end else begin
                check("lcd_rw_low", 32'(lcd_rw), 32'd0);
                if (lcd_en && !en_prev) begin
                    check("setup_data_stable", 32'(lcd_data), 32'(prev_data));
                    check("setup_rs_stable", 32'(lcd_rs), 32'(prev_rs));
                    pulse_data = lcd_data;
                    pulse_rs   = lcd_rs;
                    hi_cnt     = 1;
                    wcount++;
                    nwrites++;
                    $display("write %0d: data=%02h rs=%0d rom_addr=%0d", nwrites, lcd_data, lcd_rs, rom_addr);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 32'(lcd_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_data", 32'(lcd_data), 32'(e.data));
                        check("write_rs", 32'(lcd_rs), 32'(e.rs));
                        if (e.is_char) begin
                            check("snap_opcode", 32'(rom_opcode), 32'(e.op));
                            check("snap_imm4", 32'(rom_imm4), 32'(e.imm));
                            if (e.addr == 5'd0) char0_data = lcd_data;
                        end
                    end
                end else if (lcd_en) begin
                    hi_cnt++;
                    check("pulse_data_stable", 32'(lcd_data), 32'(pulse_data));
                    check("pulse_rs_stable", 32'(lcd_rs), 32'(pulse_rs));
                end else if (en_prev) begin
                    check("pulse_width", 32'(hi_cnt), 32'(EN));
                end
                if (!busy && busy_prev) begin
                    check("addr_wrap", 32'(rom_addr), 32'd0);
                    check("writes_per_burst", 32'(wcount), init_seen ? 32'd34 : 32'd4);
                    init_seen = 1'b1;
                    wcount = 0;
                end
                prev_data = lcd_data;
                prev_rs   = lcd_rs;
                en_prev   = lcd_en;
                busy_prev = busy;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_refresh();
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_lcd_en", 32'(lcd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_opcode", 32'(rom_opcode), 32'd0);
        check("rst_rom_imm4", 32'(rom_imm4), 32'd0);
        check("rst_lcd_data", 32'(lcd_data), 32'd0);
        check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst_lcd_rw", 32'(lcd_rw), 32'd0);
    endtask

    // From reset release: power-up quiet time, then the clear-command settle gap.
    task automatic init_phase();
        int low = 0;
        int g = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        while (low < 500) begin
            @(negedge clk);
            if (lcd_en) break;
            low++;
        end
        check("pwr_quiet_at_least", 32'(low >= PWRW && low < 500), 32'd1);
        g = 0;
        while (!(lcd_en && lcd_data == 8'h01) && g < 500) begin
            @(negedge clk); g++;
        end
        check("clear_pulse_seen", 32'(g < 500), 32'd1);
        g = 0;
        while (lcd_en && g < 50) begin
            @(negedge clk); g++;
        end
        g = 0;
        while (busy && g < 100) begin
            g++; @(negedge clk);
        end
        check("clear_gap", 32'(g), 32'(CLRW));
        check("idle_after_init", 32'(busy), 32'd0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy) && n < 4000) begin
            @(negedge clk); n++;
        end
        check(name, 32'(n < 4000), 32'd1);
        cycles(40);
        check("no_extra_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] nop, nim;
        int n;

        repeat (3) @(negedge clk);
        check_reset_values();
        push_init();
        init_phase();

        // First frame from an input change.
        @(posedge clk); #1 opcode = 4'h1; imm4 = 4'h5;
        push_frame(4'h1, 4'h5);
        drain("frame_1_5");
        check("snap_op_1", 32'(rom_opcode), 32'h1);
        check("snap_imm_5", 32'(rom_imm4), 32'h5);
        check("char0_literal", 32'(char0_data), 32'h45);

        // Refresh with unchanged inputs, then two more refreshes mid-frame.
        push_frame(4'h1, 4'h5);
        pulse_refresh();
        drain("refresh_frame");
        push_frame(4'h1, 4'h5);
        pulse_refresh();
        cycles(60);
        push_frame(4'h1, 4'h5);
        pulse_refresh();
        cycles(20);
        pulse_refresh();
        drain("refresh_collapse");

        // Opcode change mid-frame.
        nim = 4'($urandom_range(0, 15));
        @(posedge clk); #1 opcode = 4'h2; imm4 = nim;
        push_frame(4'h2, nim);
        cycles(80);
        opcode = 4'h3;
        push_frame(4'h3, nim);
        drain("opcode_change");
        check("snap_op_3", 32'(rom_opcode), 32'h3);

        // Randomized frames: either a fresh input value or a refresh.
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                push_frame(snap_op, snap_imm);
                pulse_refresh();
            end else begin
                do begin
                    nop = 4'($urandom_range(0, 15));
                    nim = 4'($urandom_range(0, 15));
                end while ({nop, nim} == {snap_op, snap_imm});
                @(posedge clk); #1 opcode = nop; imm4 = nim;
                push_frame(nop, nim);
            end
            drain("random_frame");
        end

        // Reset during an en pulse, then recovery with an automatic frame.
        push_frame(snap_op, snap_imm);
        pulse_refresh();
        n = 0;
        while (!lcd_en && n < 200) begin
            @(negedge clk); n++;
        end
        check("pulse_before_reset", 32'(lcd_en), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_values();
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_init();
        if ({opcode, imm4} != 8'h00) push_frame(opcode, imm4);
        init_phase();
        drain("post_reset_frame");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
